// File: rtl/bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : bist_pkg                                                        |
// | Purpose   : Shared state encoding and LFSR / MISR step functions for the   |
// |             BIST test-pattern generator and signature compactor.          |
// | Ports     : none (package)                                                  |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  // Both step functions work on a 32-bit container; callers cast to their width.
  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Fibonacci step: shift left, parity of the tapped bits enters the LSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                            input logic [31:0] taps,
                                            input int unsigned w);
    logic [31:0] n;
    n = {s[30:0], ^(s & taps)};
    return n & width_mask(w);
  endfunction

  // MISR step: shift left, fold the polynomial when the MSB falls out, xor data in.
  function automatic logic [31:0] misr_next(input logic [31:0] m,
                                            input logic [31:0] poly,
                                            input logic [31:0] d,
                                            input int unsigned w);
    logic [31:0] msb_mask;
    logic [31:0] n;
    msb_mask = 32'd1 << (w - 1);
    n        = {m[30:0], 1'b0};
    if ((m & msb_mask) != 32'd0) begin
      n = n ^ poly;
    end
    return (n ^ d) & width_mask(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bist_lfsr                                                       |
// | Purpose   : Fibonacci LFSR used as the BIST test-pattern generator.        |
// |             A zero seed is replaced by 1 so the register never locks up.  |
// | Ports     : clk_i   clock, rising edge                                      |
// |             rst_ni  async active-low reset (loads the seed)                |
// |             load_i  reload the seed (priority over en_i)                   |
// |             en_i    advance one step                                        |
// |             pat_o   low OUT_W bits of the register                          |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int unsigned     W     = 8,
  parameter int unsigned     OUT_W = 3,
  parameter logic [W-1:0]    TAPS  = 8'hB8,
  parameter logic [W-1:0]    SEED  = 8'h01
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] pat_o
);

  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED_EFF;
    end else if (en_i) begin
      state_d = W'(lfsr_next(32'(state_q), 32'(TAPS), W));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign pat_o = state_q[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/bist_tpg_misr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bist_tpg_misr                                                   |
// | Purpose   : BIST harness for a small sequential CUT: LFSR patterns drive   |
// |             the CUT inputs, a MISR compacts the CUT outputs, and a         |
// |             start/done controller sequences init, run and compare.         |
// | Ports     : clk_i        clock, rising edge                                 |
// |             rst_ni       async active-low reset                            |
// |             start_i      begin a run (honoured in IDLE and DONE only)      |
// |             cut_pi_o     registered CUT input vector                        |
// |             cut_po_i     CUT outputs, synchronous to clk_i                  |
// |             busy_o       high in INIT, RUN, DRAIN                           |
// |             done_o       high in DONE                                       |
// |             pass_o       signature matched GOLDEN (valid while done_o)     |
// |             signature_o  MISR contents                                      |
// |             pat_cnt_o    patterns applied in current/last run              |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bist_tpg_misr
  import bist_pkg::*;
#(
  parameter int unsigned        PI_W        = 3,
  parameter int unsigned        PO_W        = 6,
  parameter int unsigned        LFSR_W      = 8,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS   = 8'hB8,
  parameter logic [LFSR_W-1:0]  SEED        = 8'h01,
  parameter int unsigned        MISR_W      = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY   = 16'h8016,
  parameter int unsigned        N_PATTERNS  = 255,
  parameter int unsigned        INIT_CYCLES = 2,
  parameter logic [PI_W-1:0]    INIT_PI     = 3'b001,
  parameter logic [MISR_W-1:0]  GOLDEN      = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [PI_W-1:0]   cut_pi_o,
  input  logic [PO_W-1:0]   cut_po_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [MISR_W-1:0] signature_o,
  output logic [15:0]       pat_cnt_o
);

  localparam int unsigned      INIT_CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);
  localparam logic [15:0]      N_LAST     = 16'(N_PATTERNS);

  bist_state_e             state_q;
  logic [PI_W-1:0]         cut_pi_q;
  logic [MISR_W-1:0]       misr_q;
  logic [MISR_W-1:0]       misr_d;
  logic [15:0]             pat_cnt_q;
  logic [INIT_CNT_W-1:0]   init_cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;

  logic                    start_run;
  logic                    init_last;
  logic                    run_last;
  logic                    apply_pat;
  logic                    misr_en;
  logic [PI_W-1:0]         lfsr_pat;

  assign start_run = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign init_last = (state_q == INIT) && (init_cnt_q == INIT_LAST);
  assign run_last  = (state_q == RUN) && (pat_cnt_q == N_LAST);
  // The pattern for RUN cycle 1 is loaded on the INIT->RUN edge.
  assign apply_pat = init_last || ((state_q == RUN) && !run_last);

  // CUT responds one cycle after each pattern, so RUN cycle 1 carries the
  // init response and is skipped; DRAIN collects the response to the last one.
  assign misr_en = ((state_q == RUN) && (pat_cnt_q != 16'd1)) || (state_q == DRAIN);
  assign misr_d  = misr_en
                 ? MISR_W'(misr_next(32'(misr_q), 32'(MISR_POLY), 32'(cut_po_i), MISR_W))
                 : misr_q;

  bist_lfsr #(
    .W     (LFSR_W),
    .OUT_W (PI_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_tpg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (start_run),
    .en_i   (apply_pat),
    .pat_o  (lfsr_pat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cut_pi_q   <= '0;
      misr_q     <= '0;
      pat_cnt_q  <= '0;
      init_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q    <= INIT;
            cut_pi_q   <= INIT_PI;
            misr_q     <= '0;
            pat_cnt_q  <= '0;
            init_cnt_q <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        INIT: begin
          if (init_last) begin
            state_q   <= RUN;
            cut_pi_q  <= lfsr_pat;
            pat_cnt_q <= pat_cnt_q + 16'd1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        RUN: begin
          misr_q <= misr_d;
          if (run_last) begin
            state_q  <= DRAIN;
            cut_pi_q <= '0;
          end else begin
            cut_pi_q  <= lfsr_pat;
            pat_cnt_q <= pat_cnt_q + 16'd1;
          end
        end
        DRAIN: begin
          misr_q  <= misr_d;
          state_q <= DONE;
          // Compare against the value including the final capture.
          pass_q  <= (misr_d == GOLDEN);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cut_pi_o    = cut_pi_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign signature_o = misr_q;
  assign pat_cnt_o   = pat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_tpg_misr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_bist_tpg_misr                                                |
// | Purpose   : Self-checking bench for bist_tpg_misr. Two instances: a small  |
// |             4-bit-LFSR / 5-pattern configuration, and a 1-pattern one with |
// |             a zero seed. A behavioural CUT (one flop, random lookup table) |
// |             provides responses; expectations come from an arithmetic model.|
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bist_tpg_misr;

  localparam int unsigned A_N      = 5;
  localparam int unsigned A_INIT   = 2;
  localparam int unsigned A_TAPS   = 32'h9;
  localparam int unsigned A_LW     = 4;
  localparam logic [15:0] A_GOLDEN = 16'h0000;
  localparam logic [15:0] B_GOLDEN = 16'h0015;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [2:0]  pi_a, pi_b;
  logic [5:0]  po_a, po_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] sig_a, sig_b, cnt_a, cnt_b;
  logic [5:0]  g_a [8];
  logic [5:0]  g_b [8];

  int checks = 0;
  int errors = 0;

  // Behavioural CUTs: registered lookup of the current input vector.
  always_ff @(posedge clk) begin
    po_a <= g_a[pi_a];
    po_b <= g_b[pi_b];
  end

  bist_tpg_misr #(
    .PI_W(3), .PO_W(6), .LFSR_W(4), .LFSR_TAPS(4'h9), .SEED(4'h1),
    .MISR_W(16), .MISR_POLY(16'h8016), .N_PATTERNS(5), .INIT_CYCLES(2),
    .INIT_PI(3'b001), .GOLDEN(A_GOLDEN)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .cut_pi_o(pi_a), .cut_po_i(po_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .signature_o(sig_a), .pat_cnt_o(cnt_a)
  );

  bist_tpg_misr #(
    .PI_W(3), .PO_W(6), .LFSR_W(8), .LFSR_TAPS(8'hB8), .SEED(8'h00),
    .MISR_W(16), .MISR_POLY(16'h8016), .N_PATTERNS(1), .INIT_CYCLES(1),
    .INIT_PI(3'b001), .GOLDEN(B_GOLDEN)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .cut_pi_o(pi_b), .cut_po_i(po_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .signature_o(sig_b), .pat_cnt_o(cnt_b)
  );

  // ---------------- reference model ----------------
  function automatic int unsigned ref_lfsr_step(int unsigned l, int unsigned taps, int unsigned w);
    int unsigned fb;
    fb = $countones(l & taps) % 2;
    return ((l << 1) | fb) & ((32'd1 << w) - 1);
  endfunction

  function automatic logic [15:0] ref_misr(logic [15:0] m, logic [5:0] po);
    logic [16:0] t;
    t = {m, 1'b0};
    return t[15:0] ^ (t[16] ? 16'h8016 : 16'h0000) ^ {10'd0, po};
  endfunction

  // One complete run on instance A, checked cycle by cycle. Starts and ends at a negedge.
  task automatic run_a(input bit hold, input bit spur,
                       output logic [15:0] sig_seen, output logic [15:0] sig_exp);
    logic [2:0]  exp_pi [0:A_INIT+A_N+1];
    int unsigned l;
    logic [15:0] m;
    l = 1;
    m = 16'h0000;
    for (int k = 1; k <= A_INIT; k++) exp_pi[k] = 3'b001;
    for (int p = 1; p <= A_N; p++) begin
      exp_pi[A_INIT+p] = 3'(l);
      m = ref_misr(m, g_a[3'(l)]);
      l = ref_lfsr_step(l, A_TAPS, A_LW);
    end
    exp_pi[A_INIT+A_N+1] = 3'b000;
    exp_pi[0] = 3'b000;
    start_a = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= A_INIT + A_N + 1; k++) begin
      checks++;
      if (pi_a !== exp_pi[k] || busy_a !== 1'b1 || done_a !== 1'b0 || pass_a !== 1'b0) begin
        errors++;
        $display("FAIL run_a cycle %0d: pi=%0d busy=%b done=%b pass=%b, expected pi=%0d busy=1 done=0 pass=0",
                 k, pi_a, busy_a, done_a, pass_a, exp_pi[k]);
      end
      start_a = hold ? 1'b1 : (spur ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
    end
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b1 || pi_a !== 3'b000 || cnt_a !== 16'(A_N)) begin
      errors++;
      $display("FAIL run_a done_state: busy=%b done=%b pi=%0d cnt=%0d, expected busy=0 done=1 pi=0 cnt=%0d",
               busy_a, done_a, pi_a, cnt_a, A_N);
    end
    checks++;
    if (sig_a !== m) begin
      errors++;
      $display("FAIL run_a signature: got %h expected %h", sig_a, m);
    end
    checks++;
    if (pass_a !== (m == A_GOLDEN)) begin
      errors++;
      $display("FAIL run_a pass: got %b expected %b", pass_a, (m == A_GOLDEN));
    end
    sig_seen = sig_a;
    sig_exp  = m;
    start_a  = hold;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      g_a[i] = 6'h3F;
      g_b[i] = 6'h00;
    end
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, pass_a, pi_a, sig_a, cnt_a} !== 38'd0) begin
      errors++;
      $display("FAIL reset_a: busy=%b done=%b pass=%b pi=%0d sig=%h cnt=%0d, expected all 0",
               busy_a, done_a, pass_a, pi_a, sig_a, cnt_a);
    end
    checks++;
    if ({busy_b, done_b, pass_b, pi_b, sig_b, cnt_b} !== 38'd0) begin
      errors++;
      $display("FAIL reset_b: busy=%b done=%b pass=%b pi=%0d sig=%h cnt=%0d, expected all 0",
               busy_b, done_b, pass_b, pi_b, sig_b, cnt_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // Start a run and abort it in the middle of RUN.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || sig_a === 16'h0000) begin
      errors++;
      $display("FAIL pre_abort: busy=%b sig=%h, expected busy=1 and nonzero signature", busy_a, sig_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, pass_a, pi_a, sig_a, cnt_a} !== 38'd0) begin
      errors++;
      $display("FAIL async_abort: busy=%b done=%b pass=%b pi=%0d sig=%h cnt=%0d, expected all 0",
               busy_a, done_a, pass_a, pi_a, sig_a, cnt_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tpg;
    logic [15:0] s, e;
    for (int i = 0; i < 8; i++) g_a[i] = 6'($urandom);
    @(negedge clk);
    run_a(1'b0, 1'b0, s, e);
  endtask

  task automatic test_zero_response;
    logic [15:0] s, e;
    for (int i = 0; i < 8; i++) g_a[i] = 6'h00;
    @(negedge clk);
    run_a(1'b0, 1'b0, s, e);
    checks++;
    if (s !== 16'h0000 || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL zero_response: sig=%h pass=%b, expected 0000 pass=1", s, pass_a);
    end
  endtask

  task automatic test_misr_const;
    logic [15:0] s, e;
    for (int i = 0; i < 8; i++) g_a[i] = 6'h01;
    @(negedge clk);
    run_a(1'b0, 1'b0, s, e);
    // Five captures of 1: 1, 3, 7, F, 1F.
    checks++;
    if (s !== 16'h001F || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL misr_const: sig=%h pass=%b, expected 001f pass=0", s, pass_a);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s1, s2, e1, e2;
    for (int i = 0; i < 8; i++) g_a[i] = 6'($urandom);
    @(negedge clk);
    run_a(1'b1, 1'b0, s1, e1);
    run_a(1'b0, 1'b0, s2, e2);
    checks++;
    if (s2 !== s1) begin
      errors++;
      $display("FAIL back_to_back: second signature %h, first %h", s2, s1);
    end
  endtask

  task automatic test_random_runs;
    logic [15:0] s, e;
    int gap;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) g_a[i] = 6'($urandom);
      run_a(1'b0, 1'b1, s, e);
      gap = $urandom_range(1, 4);
      repeat (gap) @(negedge clk);
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || sig_a !== e || cnt_a !== 16'(A_N)) begin
        errors++;
        $display("FAIL done_hold run %0d: done=%b busy=%b sig=%h cnt=%0d, expected done=1 busy=0 sig=%h cnt=%0d",
                 r, done_a, busy_a, sig_a, cnt_a, e, A_N);
      end
    end
  endtask

  task automatic test_single_pattern;
    logic [2:0]  exp_pi [1:3];
    logic [15:0] m;
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 8; i++) g_b[i] = 6'($urandom);
      if (it == 0) g_b[1] = 6'h15;
      // Zero seed becomes 1, so the single pattern is 1.
      exp_pi[1] = 3'b001;
      exp_pi[2] = 3'b001;
      exp_pi[3] = 3'b000;
      m = ref_misr(16'h0000, g_b[1]);
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        checks++;
        if (pi_b !== exp_pi[k] || busy_b !== 1'b1 || done_b !== 1'b0) begin
          errors++;
          $display("FAIL single cycle %0d: pi=%0d busy=%b done=%b, expected pi=%0d busy=1 done=0",
                   k, pi_b, busy_b, done_b, exp_pi[k]);
        end
        @(negedge clk);
      end
      checks++;
      if (done_b !== 1'b1 || busy_b !== 1'b0 || sig_b !== m || cnt_b !== 16'd1 ||
          pass_b !== (m == B_GOLDEN)) begin
        errors++;
        $display("FAIL single done: done=%b busy=%b sig=%h cnt=%0d pass=%b, expected done=1 busy=0 sig=%h cnt=1 pass=%b",
                 done_b, busy_b, sig_b, cnt_b, pass_b, m, (m == B_GOLDEN));
      end
    end
  endtask

  initial begin
    test_reset();
    test_tpg();
    test_zero_response();
    test_misr_const();
    test_back_to_back();
    test_random_runs();
    test_single_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
